// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared types and constants for the AXI4-lite initiator
// Purpose: FSM state enum, AXI protection encodings and the read pattern
//          returned when a transaction is aborted by the watchdog.
package axi4_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [2:0]  PROT_INSN = 3'b100;
    localparam logic [2:0]  PROT_DATA = 3'b000;
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_watchdog.sv
// rtl/axi_watchdog.sv - cycle counter that flags a stalled AXI transaction
// Purpose: counts busy cycles of the initiator and raises expired on the
//          cycle the count reaches TIMEOUT_CYCLES. Instantiated only when
//          AXI_INITIATOR_TIMEOUT_EN is defined.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - hold the count at zero (initiator idle)
//   enable      - count this cycle (transaction in flight)
//   expired     - combinational: limit reached in this cycle
module axi_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count_q holds the number of busy cycles already completed, so the
    // TIMEOUT_CYCLES-th busy cycle is the one where count_q == limit - 1.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 32'd0;
        end else if (enable) begin
            count_d = count_q + 32'd1;
        end
    end

    assign expired = enable && (count_q == TIMEOUT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi4_lite_initiator.sv
// rtl/axi4_lite_initiator.sv - native memory request to single AXI4-lite transactions
// Purpose: one transaction in flight; reads use AR/R, writes issue AW and W
//          together (each completing independently) then wait for B.
//          Optional watchdog abort under AXI_INITIATOR_TIMEOUT_EN.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   mem_valid/instr/addr/wdata/wstrb - native request (wstrb == 0 means read)
//   mem_ready, mem_rdata           - one-cycle completion pulse, read data
//   mem_axi_aw*, mem_axi_w*, mem_axi_b* - AXI write channels
//   mem_axi_ar*, mem_axi_r*        - AXI read channels
//   bus_error                      - sticky watchdog flag (0 without the watchdog)
module axi4_lite_initiator
    import axi4_lite_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,

    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,

    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,

    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,

    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,

    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,

    output logic        bus_error
);

    state_e      state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arprot_q, arprot_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        timeout;

`ifdef AXI_INITIATOR_TIMEOUT_EN
    logic busy;
    assign busy = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                  (state_q == WR_REQ)  || (state_q == WR_RESP);

    axi_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .enable  (busy),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        mem_ready_d = 1'b0;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bus_error_d = bus_error_q;
        araddr_d    = araddr_q;
        arprot_d    = arprot_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_wstrb != 4'b0000) begin
                        awaddr_d  = mem_addr;
                        wdata_d   = mem_wdata;
                        wstrb_d   = mem_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = mem_addr;
                        arprot_d  = mem_instr ? PROT_INSN : PROT_DATA;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arvalid_q && mem_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready_q && mem_axi_rvalid) begin
                    rready_d    = 1'b0;
                    mem_rdata_d = mem_axi_rdata;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; the flags remember which
                // handshake has already happened.
                if (awvalid_q && mem_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && mem_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready_q && mem_axi_bvalid) begin
                    bready_d    = 1'b0;
                    mem_ready_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog abort overrides any handshake in the same cycle so the
        // requester always gets exactly one completion pulse.
        if (timeout) begin
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            bus_error_d = 1'b1;
            mem_ready_d = 1'b1;
            state_d     = DONE;
            if ((state_q == RD_ADDR) || (state_q == RD_DATA)) begin
                mem_rdata_d = ERR_RDATA;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bus_error_q <= 1'b0;
            araddr_q    <= 32'd0;
            arprot_q    <= 3'd0;
            awaddr_q    <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            mem_ready_q <= mem_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bus_error_q <= bus_error_d;
            araddr_q    <= araddr_d;
            arprot_q    <= arprot_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign mem_ready       = mem_ready_q;
    assign mem_rdata       = mem_rdata_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = awaddr_q;
    assign mem_axi_awprot  = PROT_DATA;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_bready  = bready_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = araddr_q;
    assign mem_axi_arprot  = arprot_q;
    assign mem_axi_rready  = rready_q;
    assign bus_error       = bus_error_q;

endmodule

// File: tb/tb_axi4_lite_initiator.sv
// tb/tb_axi4_lite_initiator.sv - self-checking bench for axi4_lite_initiator
module tb_axi4_lite_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_axi_awvalid;
    logic        mem_axi_awready = 1'b0;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid;
    logic        mem_axi_wready = 1'b0;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid = 1'b0;
    logic        mem_axi_bready;
    logic        mem_axi_arvalid;
    logic        mem_axi_arready = 1'b0;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid = 1'b0;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata = 32'd0;
    logic        bus_error;

    always #5 clk = ~clk;

    axi4_lite_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_valid       (mem_valid),
        .mem_instr       (mem_instr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .mem_axi_awvalid (mem_axi_awvalid),
        .mem_axi_awready (mem_axi_awready),
        .mem_axi_awaddr  (mem_axi_awaddr),
        .mem_axi_awprot  (mem_axi_awprot),
        .mem_axi_wvalid  (mem_axi_wvalid),
        .mem_axi_wready  (mem_axi_wready),
        .mem_axi_wdata   (mem_axi_wdata),
        .mem_axi_wstrb   (mem_axi_wstrb),
        .mem_axi_bvalid  (mem_axi_bvalid),
        .mem_axi_bready  (mem_axi_bready),
        .mem_axi_arvalid (mem_axi_arvalid),
        .mem_axi_arready (mem_axi_arready),
        .mem_axi_araddr  (mem_axi_araddr),
        .mem_axi_arprot  (mem_axi_arprot),
        .mem_axi_rvalid  (mem_axi_rvalid),
        .mem_axi_rready  (mem_axi_rready),
        .mem_axi_rdata   (mem_axi_rdata),
        .bus_error       (bus_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Responder memory (written only through the AXI write channels) and the
    // bench's reference memory (written from the requests issued).
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] k);
        return {k[15:0], ~k[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rsp_word(input logic [31:0] k);
        return mem.exists(k) ? mem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] ctl_outs();
        return {25'd0, mem_axi_arvalid, mem_axi_rready, mem_axi_awvalid, mem_axi_wvalid,
                mem_axi_bready, mem_ready, bus_error};
    endfunction

    // Responder: decides at each falling edge what the next rising edge sees.
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    int aw_hi = 0, w_hi = 0, b_hi = 0, rdy_hi = 0, viol = 0;
    logic ar_fire = 0, r_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0;
    logic prev_ar = 0, prev_aw = 0, prev_w = 0;
    logic aw_have = 0, w_have = 0, b_pending = 0;
    logic [31:0] rd_q[$];
    logic [31:0] last_araddr = 0, last_awaddr = 0, last_wdata = 0;
    logic [2:0]  last_arprot = 0, last_awprot = 0;
    logic [3:0]  last_wstrb = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_axi_arready = 0; mem_axi_rvalid = 0; mem_axi_awready = 0;
                mem_axi_wready = 0;  mem_axi_bvalid = 0;
                ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
                prev_ar = 0; prev_aw = 0; prev_w = 0;
                aw_have = 0; w_have = 0; b_pending = 0; rd_q.delete();
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (mem_axi_awvalid) aw_hi++;
                if (mem_axi_wvalid)  w_hi++;
                if (mem_axi_bready)  b_hi++;
                if (mem_ready)       rdy_hi++;
                if (!bus_error) begin
                    if (prev_ar && !ar_fire && !mem_axi_arvalid) viol++;
                    if (prev_aw && !aw_fire && !mem_axi_awvalid) viol++;
                    if (prev_w  && !w_fire  && !mem_axi_wvalid)  viol++;
                end
                if (ar_fire) begin rd_q.push_back(last_araddr >> 2); mem_axi_arready = 0; end
                if (r_fire)  mem_axi_rvalid = 0;
                if (aw_fire) begin mem_axi_awready = 0; aw_have = 1; end
                if (w_fire)  begin mem_axi_wready = 0;  w_have = 1; end
                if (aw_have && w_have) begin
                    mem[last_awaddr >> 2] = merge(rsp_word(last_awaddr >> 2), last_wdata, last_wstrb);
                    aw_have = 0; w_have = 0; b_pending = 1;
                end
                if (b_fire) mem_axi_bvalid = 0;

                if (mem_axi_arvalid && !mem_axi_arready) begin
                    if (ar_cnt >= ar_wait) begin
                        mem_axi_arready = 1; ar_cnt = 0;
                        last_araddr = mem_axi_araddr; last_arprot = mem_axi_arprot;
                    end else ar_cnt++;
                end
                if (rd_q.size() > 0 && !mem_axi_rvalid) begin
                    if (r_cnt >= r_wait) begin
                        mem_axi_rvalid = 1; r_cnt = 0;
                        mem_axi_rdata = rsp_word(rd_q.pop_front());
                    end else r_cnt++;
                end
                if (mem_axi_awvalid && !mem_axi_awready) begin
                    if (aw_cnt >= aw_wait) begin
                        mem_axi_awready = 1; aw_cnt = 0;
                        last_awaddr = mem_axi_awaddr; last_awprot = mem_axi_awprot;
                    end else aw_cnt++;
                end
                if (mem_axi_wvalid && !mem_axi_wready) begin
                    if (w_cnt >= w_wait) begin
                        mem_axi_wready = 1; w_cnt = 0;
                        last_wdata = mem_axi_wdata; last_wstrb = mem_axi_wstrb;
                    end else w_cnt++;
                end
                if (b_pending && !mem_axi_bvalid) begin
                    if (b_cnt >= b_wait) begin
                        mem_axi_bvalid = 1; b_cnt = 0; b_pending = 0;
                    end else b_cnt++;
                end

                ar_fire = mem_axi_arvalid && mem_axi_arready;
                r_fire  = mem_axi_rvalid  && mem_axi_rready;
                aw_fire = mem_axi_awvalid && mem_axi_awready;
                w_fire  = mem_axi_wvalid  && mem_axi_wready;
                b_fire  = mem_axi_bvalid  && mem_axi_bready;
                prev_ar = mem_axi_arvalid;
                prev_aw = mem_axi_awvalid;
                prev_w  = mem_axi_wvalid;
            end
        end
    end

    // Issues one request; lat counts falling edges from the request until
    // mem_ready is seen (zero-wait responder gives 3).
    task automatic do_txn(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output int lat, output logic [31:0] rd);
        @(negedge clk);
        mem_valid = 1; mem_instr = instr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
        aw_hi = 0; w_hi = 0; b_hi = 0; rdy_hi = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_ready && lat < 200);
        check("txn_done", {31'd0, mem_ready}, 32'd1);
        rd = mem_rdata;
        mem_valid = 0; mem_wstrb = 4'd0;
        if (strb != 4'd0) ref_mem[addr >> 2] = merge(ref_word(addr >> 2), wdata, strb);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int exp_lat;
        logic [31:0] rd;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        ins;

        repeat (3) @(negedge clk);
        check("reset_ctl", ctl_outs(), 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        reset = 0;
        repeat (2) @(negedge clk);
        check("idle_ctl", ctl_outs(), 32'd0);
        check("idle_araddr", mem_axi_araddr, 32'd0);

        // Instruction fetch, zero-wait responder.
        mem[32'h4] = 32'h1234_5678;
        ref_mem[32'h4] = 32'h1234_5678;
        do_txn(1'b1, 32'h0000_0010, 32'd0, 4'd0, lat, rd);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_data", rd, 32'h1234_5678);
        check("rd_araddr", last_araddr, 32'h0000_0010);
        check("rd_arprot", {29'd0, last_arprot}, 32'd4);

        // Write with W delayed 3 cycles behind AW.
        w_wait = 3;
        do_txn(1'b0, 32'h1000_0000, 32'h0000_0041, 4'b0001, lat, rd);
        check("wr_aw_cycles", 32'(aw_hi), 32'd1);
        check("wr_w_cycles", 32'(w_hi), 32'd4);
        check("wr_latency", 32'(lat), 32'd6);
        check("wr_awaddr", last_awaddr, 32'h1000_0000);
        check("wr_awprot", {29'd0, last_awprot}, 32'd0);
        check("wr_wdata", last_wdata, 32'h0000_0041);
        check("wr_wstrb", {28'd0, last_wstrb}, 32'd1);
        check("wr_rdata_kept", rd, 32'h1234_5678);
        repeat (3) @(negedge clk);
        check("wr_one_ready", 32'(rdy_hi), 32'd1);
        w_wait = 0;
        do_txn(1'b0, 32'h1000_0000, 32'd0, 4'd0, lat, rd);
        check("wr_readback", rd, 32'h0000_FF41);

        // Write with B delayed.
        b_wait = 4;
        do_txn(1'b0, 32'h2000_0000, 32'd123456789, 4'hF, lat, rd);
        check("b_ready_cycles", 32'(b_hi), 32'd5);
        check("b_latency", 32'(lat), 32'd7);
        b_wait = 0;
        do_txn(1'b0, 32'h2000_0000, 32'd0, 4'd0, lat, rd);
        check("b_readback", rd, 32'd123456789);

        // Reset while waiting in RD_DATA.
        r_wait = 10;
        @(negedge clk);
        mem_valid = 1; mem_instr = 0; mem_addr = 32'h0000_0010; mem_wstrb = 4'd0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_axi_rready && lat < 20);
        check("reach_rd_data", {31'd0, mem_axi_rready}, 32'd1);
        reset = 1;
        mem_valid = 0;
        #1;
        check("midrst_ctl", ctl_outs(), 32'd0);
        check("midrst_rdata", mem_rdata, 32'd0);
        check("midrst_araddr", mem_axi_araddr, 32'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        r_wait = 0;
        do_txn(1'b0, 32'h0000_0010, 32'd0, 4'd0, lat, rd);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_data", rd, 32'h1234_5678);

        // Randomised waits over mixed reads and writes.
        for (int i = 0; i < 1000; i++) begin
            ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
            aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3);
            b_wait = $urandom_range(0, 3);
            a = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            s = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            d = $urandom;
            ins = 1'($urandom_range(0, 1));
            exp_lat = (s != 4'd0) ? 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) + b_wait
                                  : 3 + ar_wait + r_wait;
            do_txn(ins, a, d, s, lat, rd);
            check("rand_latency", 32'(lat), 32'(exp_lat));
            if (s == 4'd0) check("rand_rdata", rd, ref_word(a >> 2));
        end
        check("no_valid_drop", 32'(viol), 32'd0);
        ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;

`ifdef AXI_INITIATOR_TIMEOUT_EN
        ar_wait = 100000;
        do_txn(1'b1, 32'h0000_0040, 32'd0, 4'd0, lat, rd);
        check("wd_latency", 32'(lat), 32'd17);
        check("wd_bus_error", {31'd0, bus_error}, 32'd1);
        check("wd_rdata", rd, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        check("wd_sticky", {31'd0, bus_error}, 32'd1);
        reset = 1;
        @(negedge clk);
        check("wd_cleared", {31'd0, bus_error}, 32'd0);
        reset = 0;
        ar_wait = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
